// File: rtl/ddr_cmd_pkg.sv
// Types and widths shared by the DRAM responder and the DDR controller's command path.
package ddr_cmd_pkg;

    localparam int DDR_ADDR_W = 15;
    localparam int DDR_BA_W   = 3;
    localparam int DDR_DQ_W   = 16;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLAT,
        ST_WDATA,
        ST_RLAT,
        ST_RDATA
    } burst_state_e;

    function automatic logic is_col_cmd(input cmd_e c);
        return (c == CMD_RD) || (c == CMD_WR);
    endfunction

endpackage

// File: rtl/ddr_cmd_decode.sv
// Combinational DDR command decoder: CKE low or CS high always reads as NOP.
module ddr_cmd_decode
    import ddr_cmd_pkg::*;
(
    input  logic cs_i,
    input  logic ras_i,
    input  logic cas_i,
    input  logic we_i,
    input  logic cke_i,
    output cmd_e cmd_o
);

    always_comb begin
        cmd_o = CMD_NOP;
        if (cke_i && !cs_i) begin
            case ({ras_i, cas_i, we_i})
                3'b011:  cmd_o = CMD_ACT;
                3'b101:  cmd_o = CMD_RD;
                3'b100:  cmd_o = CMD_WR;
                3'b010:  cmd_o = CMD_PRE;
                3'b001:  cmd_o = CMD_REF;
                3'b000:  cmd_o = CMD_MRS;
                default: cmd_o = CMD_NOP;
            endcase
        end
    end

endmodule

// File: rtl/ddr_dram_responder.sv
// Simplified SDR-timed DRAM device: per-bank open-row tracking, fixed-latency
// write/read bursts into a small internal array, sticky protocol error flag.
module ddr_dram_responder
    import ddr_cmd_pkg::*;
#(
    parameter int CL       = 5,
    parameter int CWL      = 5,
    parameter int BL       = 8,
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic                  CK,
    input  logic                  RESET,
    input  logic                  CKE,
    input  logic                  CS,
    input  logic                  RAS,
    input  logic                  CAS,
    input  logic                  WE,
    input  logic [DDR_ADDR_W-1:0] Addr_in,
    input  logic [DDR_BA_W-1:0]   BA_in,
    input  logic                  LDM,
    input  logic                  UDM,
    inout  wire  [DDR_DQ_W-1:0]   DQ,
    inout  wire                   LDQS,
    inout  wire                   LDQS_n,
    inout  wire                   UDQS,
    inout  wire                   UDQS_n,
    output logic [7:0]            open_banks,
    output logic                  proto_err
);

    localparam int NBANK   = 2 ** DDR_BA_W;
    localparam int BEAT_W  = $clog2(BL);
    localparam int BLK_W   = COL_BITS - BEAT_W;
    localparam int MEM_AW  = DDR_BA_W + ROW_BITS + COL_BITS;
    localparam int MAX_LAT = (CL > CWL) ? CL : CWL;
    localparam int LAT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    // Latency counters run from load value down to zero, then switch state,
    // so the data phase begins on the (latency-1)-th edge after the command.
    localparam logic [LAT_W-1:0]  RD_LOAD   = LAT_W'(CL - 2);
    localparam logic [LAT_W-1:0]  WR_LOAD   = LAT_W'(CWL - 2);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BL - 1);

    cmd_e                  cmd;
    burst_state_e          state_q;
    logic [NBANK-1:0]      open_q;
    logic [ROW_BITS-1:0]   row_tab_q [NBANK];
    logic                  err_q;
    logic [DDR_BA_W-1:0]   bank_q;
    logic [ROW_BITS-1:0]   row_q;
    logic [BLK_W-1:0]      blk_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [LAT_W-1:0]      lat_q;
    logic [DDR_DQ_W-1:0]   dq_q;
    logic                  dq_oe_q;
    logic                  dqs_oe_q;
    logic                  start;
    logic                  wr_en;
    logic [MEM_AW-1:0]     beat_addr;
    logic [DDR_DQ_W-1:0]   rd_data;
    logic                  strobe;
    logic                  addr_unused;

    logic [DDR_DQ_W-1:0]   mem [2 ** MEM_AW];

    ddr_cmd_decode u_decode (
        .cs_i  (CS),
        .ras_i (RAS),
        .cas_i (CAS),
        .we_i  (WE),
        .cke_i (CKE),
        .cmd_o (cmd)
    );

    assign addr_unused = ^Addr_in;
    assign start       = is_col_cmd(cmd) && open_q[BA_in] && (state_q == ST_IDLE);
    assign beat_addr   = {bank_q, row_q, blk_q, beat_q};
    assign rd_data     = mem[beat_addr];
    assign wr_en       = (state_q == ST_WDATA);

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            open_q   <= '0;
            err_q    <= 1'b0;
            bank_q   <= '0;
            row_q    <= '0;
            blk_q    <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            dq_q     <= '0;
            dq_oe_q  <= 1'b0;
            dqs_oe_q <= 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                row_tab_q[b] <= '0;
            end
        end else begin
            case (cmd)
                CMD_ACT: begin
                    if (open_q[BA_in]) err_q <= 1'b1;
                    open_q[BA_in]    <= 1'b1;
                    row_tab_q[BA_in] <= Addr_in[ROW_BITS-1:0];
                end
                CMD_PRE: begin
                    if (Addr_in[10]) open_q <= '0;
                    else             open_q[BA_in] <= 1'b0;
                end
                CMD_RD, CMD_WR: begin
                    if (!open_q[BA_in] || (state_q != ST_IDLE)) err_q <= 1'b1;
                end
                default: ;
            endcase

            // Strobe preamble starts one cycle ahead of the first read beat.
            dq_oe_q  <= (state_q == ST_RDATA);
            dqs_oe_q <= (state_q == ST_RDATA) || ((state_q == ST_RLAT) && (lat_q == '0));

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bank_q  <= BA_in;
                        row_q   <= row_tab_q[BA_in];
                        blk_q   <= Addr_in[COL_BITS-1:BEAT_W];
                        beat_q  <= '0;
                        lat_q   <= (cmd == CMD_RD) ? RD_LOAD : WR_LOAD;
                        state_q <= (cmd == CMD_RD) ? ST_RLAT : ST_WLAT;
                    end
                end
                ST_WLAT, ST_RLAT: begin
                    if (lat_q == '0) state_q <= (state_q == ST_WLAT) ? ST_WDATA : ST_RDATA;
                    else             lat_q   <= lat_q - 1'b1;
                end
                ST_WDATA: begin
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) state_q <= ST_IDLE;
                end
                ST_RDATA: begin
                    dq_q   <= rd_data;
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Array contents survive reset; each byte lane has its own mask.
    always_ff @(posedge CK) begin
        if (wr_en) begin
            if (!LDM) mem[beat_addr][7:0]  <= DQ[7:0];
            if (!UDM) mem[beat_addr][15:8] <= DQ[15:8];
        end
    end

    assign strobe = dq_oe_q ? CK : 1'b0;

    assign DQ     = dq_oe_q  ? dq_q    : {DDR_DQ_W{1'bz}};
    assign LDQS   = dqs_oe_q ? strobe  : 1'bz;
    assign UDQS   = dqs_oe_q ? strobe  : 1'bz;
    assign LDQS_n = dqs_oe_q ? ~strobe : 1'bz;
    assign UDQS_n = dqs_oe_q ? ~strobe : 1'bz;

    assign open_banks = open_q;
    assign proto_err  = err_q;

endmodule

// File: doc/ddr_dram_responder.md
Name: ddr_dram_responder

Overview:
- Simplified synthesizable DRAM device model: the memory end of the command/data interface our DDR controller drives (CS/RAS/CAS/WE, Addr, BA, DQ, DQS, DM).
- Decodes commands, tracks an open row per bank, stores write bursts in a small internal array and returns read bursts after CL.
- Used as the far-end model in system benches and as an on-board loopback target.
- The data path is single-data-rate: one beat per CK rising edge.

Parameters:
- CL, 5, read latency in CK cycles from READ command to first driven beat.
- CWL, 5, write latency in CK cycles from WRITE command to first captured beat.
- BL, 8, burst length in beats; power of two, 2..8.
- ROW_BITS, 4, low row-address bits stored; Addr_in[ROW_BITS-1:0].
- COL_BITS, 6, column bits stored; Addr_in[COL_BITS-1:0]; must be >= log2(BL).

Ports:
- CK  in  1  device clock; everything samples on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CKE  in  1  clock enable; when low, all commands are decoded as NOP.
- CS  in  1  chip select, active-low.
- RAS  in  1  row strobe, active-low.
- CAS  in  1  column strobe, active-low.
- WE  in  1  write enable, active-low.
- Addr_in  in  15  row (ACT) or column (READ/WRITE) address.
- BA_in  in  3  bank address.
- LDM  in  1  write mask, lower byte, active-high.
- UDM  in  1  write mask, upper byte, active-high.
- DQ  inout  16  data bus; driven only during read bursts.
- LDQS, LDQS_n, UDQS, UDQS_n  inout  1 each  strobes; driven only during read bursts.
- open_banks  out  8  bit b = 1 while bank b has an open row.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous): open_banks=0, proto_err=0, burst engine IDLE, DQ/DQS high-Z. Memory contents are not reset.
- Command decode happens when CS=0 and CKE=1, using {RAS,CAS,WE}:
  - 011 ACT: open row Addr_in[ROW_BITS-1:0] in BA_in.
  - 101 READ.
  - 100 WRITE.
  - 010 PRE: close bank BA_in. If Addr_in[10]=1, close all banks.
  - 001 REF: accepted; no effect.
  - 000 MRS: accepted; no effect.
  - 111 NOP.
- CS=1 is NOP.
- ACT to a bank that is already open: proto_err set; the row is replaced.
- PRE to a closed bank: legal; no effect.
- READ or WRITE to a closed bank: proto_err set; command dropped.
- Burst FSM states: IDLE, WLAT, WDATA, RLAT, RDATA.
  - IDLE accepts READ/WRITE. It latches bank, row and column, with column aligned down to a multiple of BL, and loads the latency counter.
  - WRITE: IDLE -> WLAT, which counts CWL-1 cycles -> WDATA.
  - WDATA captures DQ on each of BL consecutive edges into address {bank,row,col+beat}. LDM=1 / UDM=1 suppresses the write of the corresponding byte. Then -> IDLE.
  - The first beat is captured on the CWL-th rising edge after the command edge.
  - READ: IDLE -> RLAT (CL-1 cycles) -> RDATA.
  - RDATA drives DQ from {bank,row,col+beat} for BL cycles. The first beat is valid after the CL-th rising edge following the command edge; that means combinational read plus registered output, 1 beat per cycle. Then -> IDLE, and DQ returns to high-Z on the next edge.
- Strobes during RDATA:
  - LDQS=UDQS = CK-phase toggle, starting at 1 on beat 0; LDQS_n and UDQS_n are the complements.
  - One preamble cycle before beat 0: strobes driven at 0.
  - Outside the read burst, DQ and all strobes are high-Z.
- Any READ/WRITE received while the FSM is not IDLE: proto_err set; the command is dropped. The active burst continues.
- PRE to the bank of an active burst: the bank closes; the burst still completes to the latched row.
- Column wrap: beat addresses wrap within the BL-aligned block (col[log2 BL-1:0] increments mod BL).
- Reset mid-burst: FSM -> IDLE immediately and DQ goes high-Z. Memory keeps any beats already written.
- Memory array: 8 × 2^ROW_BITS × 2^COL_BITS words of 16 bits. Simulation initial value is X.

Decomposition:
- Package ddr_cmd_pkg holds:
  - command enum (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS), shared with the controller;
  - burst-FSM state enum;
  - DDR_ADDR_W=15, DDR_BA_W=3, DDR_DQ_W=16.
- Sub-module ddr_cmd_decode: combinational {CS,RAS,CAS,WE,CKE} -> command enum. Shared with the controller's command monitor.

Test Plan:
- Reset, then ACT bank 2 row 3 -> open_banks=8'h04, proto_err=0.
- ACT b2 r3; WRITE col 0x10 with beats 0x1000..0x1007, DM=0; READ col 0x10 -> DQ first beat 0x1000 exactly CL cycles after READ; 8 consecutive beats ending 0x1007; DQ high-Z afterwards.
- WRITE col 0x14 with beats A0..A7, BL=8 -> write starts at aligned 0x10. Readback order is A0..A7 at cols 0x10..0x17. Second write with UDM=1 on beat 3 value 0xBEEF -> readback beat 3 = {old upper byte, 0xEF}.
- READ to closed bank 5 -> proto_err=1, DQ stays high-Z. proto_err stays 1 through a following legal burst.
- WRITE issued 2 cycles after a READ -> proto_err=1; the read burst completes unchanged.
- Assert RESET during RDATA beat 3 -> DQ high-Z within the same cycle, open_banks=0. After re-ACT, a READ returns the data previously written.
